counter_checker: RTL and testbench
==================================

# counter_checker

Sequential monitor that sits on the output bus of a free-running `counter` and checks that the value advances by exactly one, modulo 2^W, on every clock. It tracks lock, counts wrap-arounds, pulses on each discontinuity, and records the first failure since reset. It is the consuming end of the counter's `value` bus, used in simulation and as an on-chip health check.

## Interface
- `W`, 32: width of the observed value.
- `LOCK_N`, 4: number of consecutive correct increments required to assert `locked` (≥1).
- `CW`, 16: width of the `err_count` and `wrap_count` counters.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high; clears all state on the next rising edge.
- `value`  in  W: observed counter output, sampled every rising edge.
- `locked`  out  1: high while at least LOCK_N consecutive correct increments have been seen.
- `err`  out  1: one-cycle pulse per detected discontinuity.
- `err_count`  out  CW: saturating count of discontinuities since reset.
- `wrap_count`  out  CW: saturating count of correct all-ones→0 transitions since reset.
- `first_valid`  out  1: high once a discontinuity has been captured.
- `first_expected`  out  W: expected value at the first discontinuity.
- `first_actual`  out  W: sampled value at the first discontinuity.

## Operation
- Internal registers: `prev` (W), `run` (counts to LOCK_N), state ∈ {IDLE, TRACK, LOCKED}.
- `reset` high at an edge: state←IDLE, `prev`←0, `run`←0, all outputs←0. Reset has priority over everything.
- IDLE: the first edge with `reset` low stores `prev`←`value` and moves to TRACK, with `run`←0. No comparison is made and `err` stays low.
- TRACK/LOCKED, at each edge: `expected` = `prev`+1, truncated to W bits, so all-ones wraps to 0. The checker always updates `prev`←`value`.
- Match (`value`==`expected`):
  - `run`←min(`run`+1, LOCK_N).
  - TRACK→LOCKED when the new `run` equals LOCK_N.
  - If `prev` is all-ones, `wrap_count` increments, saturating at 2^CW−1.
- Mismatch:
  - `err`←1 for that cycle and `err_count` increments, saturating.
  - State←TRACK and `run`←0. The sampled value becomes the new baseline (resync).
  - If `first_valid` is 0, the checker captures `first_expected`←`expected` and `first_actual`←`value`, and sets `first_valid`←1. Later mismatches never overwrite the capture.
- `locked` = (state==LOCKED), registered.
- Counter reset alone, with the checker not in reset, shows up as a mismatch unless `prev` was all-ones. It is counted as an error, and the checker resyncs at 0.
- Shared reset (same `reset` wire as the counter): the checker re-enters IDLE. No error is raised.

## Timing
- All outputs are registered. They update on the same rising edge that samples the causing `value`.
- `err` is high for exactly the one cycle following a mismatching sample. Back-to-back mismatches produce `err` high on consecutive cycles, and `err_count` increments each time.
- Lock latency from release of reset with a correct counter: 1 edge to baseline, plus LOCK_N edges. `locked` rises at edge LOCK_N+1 after reset deasserts.
- After a mismatch, `locked` falls at that same edge and re-rises LOCK_N correct edges later.
- Saturation: at 2^CW−1, `err_count` and `wrap_count` hold their value. `err` still pulses.
- A mismatch on the edge that would complete LOCK_N is treated as a mismatch and does not lock.

## Test plan
Parameters for all scenarios: W=8, LOCK_N=4, CW=4.
- Reset, then a correct counter running from 0. `locked`=0 through edge 4 and rises at edge 5. `err` is never asserted, and `err_count`=0.
- Correct count through 0xFE, 0xFF, 0x00, 0x01. `wrap_count` goes 0→1 on the 0x00 sample, with no `err`.
- Locked at value 0x10, then 0x15 is forced. `err` pulses for 1 cycle, `locked` drops, and `err_count`=1. The capture shows `first_expected`=0x11 and `first_actual`=0x15. The checker re-locks after 0x16..0x19.
- Second glitch after the third scenario. `err_count`=2, and `first_*` still hold 0x11/0x15.
- Counter reset alone at value 0x40. `err` pulses, with expected 0x41 and actual 0x00. Pulsing the shared `reset` mid-count instead returns all outputs to 0 and raises no `err`.
- 20 consecutive mismatches. `err` is high for 20 cycles and `err_count` saturates at 15.

Source files
------------

// File: rtl/counter_checker.sv
// counter_checker: watches a free-running counter's value bus and flags any
// step other than +1 (mod 2^W). Tracks lock, counts wraps and discontinuities,
// and keeps the first discontinuity seen since reset.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | out of reset; next sample becomes the baseline, no compare
//   TRACK  | comparing each sample to prev+1; fewer than LOCK_N good steps
//   LOCKED | at least LOCK_N consecutive correct increments seen
module counter_checker #(
  parameter int W      = 32,
  parameter int LOCK_N = 4,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  value,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] wrap_count,
  output logic          first_valid,
  output logic [W-1:0]  first_expected,
  output logic [W-1:0]  first_actual
);

  localparam int RW = $clog2(LOCK_N + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  prev_q, prev_d;
  logic [RW-1:0] run_q, run_d;
  logic          err_d;
  logic [CW-1:0] err_count_d, wrap_count_d;
  logic          first_valid_d;
  logic [W-1:0]  first_expected_d, first_actual_d;
  logic [W-1:0]  expected;

  assign expected = prev_q + 1'b1;

  // next-state and next-output decode; every sample replaces the baseline
  always_comb begin
    state_d          = state_q;
    prev_d           = prev_q;
    run_d            = run_q;
    err_d            = 1'b0;
    err_count_d      = err_count;
    wrap_count_d     = wrap_count;
    first_valid_d    = first_valid;
    first_expected_d = first_expected;
    first_actual_d   = first_actual;

    case (state_q)
      IDLE: begin
        prev_d  = value;
        run_d   = '0;
        state_d = TRACK;
      end
      TRACK, LOCKED: begin
        prev_d = value;
        if (value == expected) begin
          if (run_q != RUN_MAX) run_d = run_q + 1'b1;
          if (run_d == RUN_MAX) state_d = LOCKED;
          if ((prev_q == '1) && (wrap_count != '1)) wrap_count_d = wrap_count + 1'b1;
        end else begin
          err_d   = 1'b1;
          run_d   = '0;
          state_d = TRACK;
          if (err_count != '1) err_count_d = err_count + 1'b1;
          if (!first_valid) begin
            first_valid_d    = 1'b1;
            first_expected_d = expected;
            first_actual_d   = value;
          end
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
  end

  // state and output registers; synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      prev_q         <= '0;
      run_q          <= '0;
      err            <= 1'b0;
      err_count      <= '0;
      wrap_count     <= '0;
      first_valid    <= 1'b0;
      first_expected <= '0;
      first_actual   <= '0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      run_q          <= run_d;
      err            <= err_d;
      err_count      <= err_count_d;
      wrap_count     <= wrap_count_d;
      first_valid    <= first_valid_d;
      first_expected <= first_expected_d;
      first_actual   <= first_actual_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker with W=8, LOCK_N=4, CW=4.
module tb_counter_checker;

  logic       clk;
  logic       reset;
  logic [7:0] value;
  logic       locked;
  logic       err;
  logic [3:0] err_count;
  logic [3:0] wrap_count;
  logic       first_valid;
  logic [7:0] first_expected;
  logic [7:0] first_actual;

  int n_vec  = 0;
  int n_miss = 0;

  counter_checker #(.W(8), .LOCK_N(4), .CW(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .value         (value),
    .locked        (locked),
    .err           (err),
    .err_count     (err_count),
    .wrap_count    (wrap_count),
    .first_valid   (first_valid),
    .first_expected(first_expected),
    .first_actual  (first_actual)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic r, input logic [7:0] v);
    @(negedge clk);
    reset = r;
    value = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".locked"}, 32'(locked), 0);
    chk({tag, ".err"}, 32'(err), 0);
    chk({tag, ".err_count"}, 32'(err_count), 0);
    chk({tag, ".wrap_count"}, 32'(wrap_count), 0);
    chk({tag, ".first_valid"}, 32'(first_valid), 0);
    chk({tag, ".first_expected"}, 32'(first_expected), 0);
    chk({tag, ".first_actual"}, 32'(first_actual), 0);
  endtask

  int exp_ec;

  initial begin
    reset = 1'b1;
    value = 8'h00;

    // reset state
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    chk_cleared("reset");

    // lock latency: baseline at edge 1, locked at edge 5
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'(i));
      chk($sformatf("lock.e%0d.locked", i + 1), 32'(locked), (i == 4) ? 1 : 0);
      chk($sformatf("lock.e%0d.err", i + 1), 32'(err), 0);
    end
    chk("lock.err_count", 32'(err_count), 0);

    // run up to the wrap
    for (int v = 5; v <= 8'hFE; v++) begin
      step(1'b0, 8'(v));
      chk($sformatf("run.%0h.err", v), 32'(err), 0);
    end
    chk("wrap.pre.wrap_count", 32'(wrap_count), 0);
    step(1'b0, 8'hFF);
    chk("wrap.ff.wrap_count", 32'(wrap_count), 0);
    step(1'b0, 8'h00);
    chk("wrap.00.wrap_count", 32'(wrap_count), 1);
    chk("wrap.00.err", 32'(err), 0);
    chk("wrap.00.locked", 32'(locked), 1);
    step(1'b0, 8'h01);
    chk("wrap.01.wrap_count", 32'(wrap_count), 1);

    // glitch while locked at 0x10
    for (int v = 2; v <= 8'h10; v++) step(1'b0, 8'(v));
    chk("glitch1.pre.locked", 32'(locked), 1);
    step(1'b0, 8'h15);
    chk("glitch1.err", 32'(err), 1);
    chk("glitch1.locked", 32'(locked), 0);
    chk("glitch1.err_count", 32'(err_count), 1);
    chk("glitch1.first_valid", 32'(first_valid), 1);
    chk("glitch1.first_expected", 32'(first_expected), 8'h11);
    chk("glitch1.first_actual", 32'(first_actual), 8'h15);
    step(1'b0, 8'h16);
    chk("relock.16.err", 32'(err), 0);
    chk("relock.16.locked", 32'(locked), 0);
    step(1'b0, 8'h17);
    step(1'b0, 8'h18);
    chk("relock.18.locked", 32'(locked), 0);
    step(1'b0, 8'h19);
    chk("relock.19.locked", 32'(locked), 1);

    // second glitch keeps the first capture
    step(1'b0, 8'h30);
    chk("glitch2.err", 32'(err), 1);
    chk("glitch2.err_count", 32'(err_count), 2);
    chk("glitch2.first_expected", 32'(first_expected), 8'h11);
    chk("glitch2.first_actual", 32'(first_actual), 8'h15);
    chk("glitch2.wrap_count", 32'(wrap_count), 1);
    step(1'b0, 8'h31);
    chk("glitch2.resync.err", 32'(err), 0);

    // shared reset mid-count clears everything without an error
    step(1'b1, 8'h32);
    chk_cleared("shared_rst");
    step(1'b0, 8'h30);
    chk("shared_rst.idle.err", 32'(err), 0);

    // counter reset alone at 0x40
    for (int v = 8'h31; v <= 8'h40; v++) step(1'b0, 8'(v));
    chk("ctr_rst.pre.locked", 32'(locked), 1);
    step(1'b0, 8'h00);
    chk("ctr_rst.err", 32'(err), 1);
    chk("ctr_rst.err_count", 32'(err_count), 1);
    chk("ctr_rst.first_expected", 32'(first_expected), 8'h41);
    chk("ctr_rst.first_actual", 32'(first_actual), 8'h00);
    step(1'b0, 8'h01);
    chk("ctr_rst.resync.err", 32'(err), 0);

    // 20 back-to-back mismatches: err stays high, err_count saturates at 15
    exp_ec = 1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h80);
      exp_ec = (exp_ec < 15) ? exp_ec + 1 : 15;
      chk($sformatf("burst.%0d.err", i), 32'(err), 1);
      chk($sformatf("burst.%0d.err_count", i), 32'(err_count), 32'(exp_ec));
    end
    chk("burst.final.err_count", 32'(err_count), 15);
    step(1'b0, 8'h81);
    chk("burst.after.err", 32'(err), 0);
    chk("burst.after.err_count", 32'(err_count), 15);
    chk("burst.after.first_expected", 32'(first_expected), 8'h41);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
